// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped read-only cache controller.
// Imported by the store, the controller and the bench.
package cache_pkg;

  localparam int LINE_W    = 2;
  localparam int NUM_LINES = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    FILL    = 2'd2,
    RESPOND = 2'd3
  } cache_state_e;

  // Tag is everything above the line index.
  function automatic int tag_width(input int addr_w);
    return addr_w - LINE_W;
  endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// CPU read port and single-beat memory refill port of the cache controller.
// Handshakes: cpu_req is a level held by the requester until the cycle after
// the one-cycle cpu_ready pulse; mem_req is a level held by the controller
// until mem_ack, a one-cycle pulse that also qualifies mem_rdata.
interface cache_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ready;
  logic [DATA_W-1:0] cpu_rdata;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  // Environment side: CPU requester and memory responder.
  modport master (
    output cpu_req, cpu_addr, mem_rdata, mem_ack,
    input  cpu_ready, cpu_rdata, mem_req, mem_addr
  );

  // Controller side.
  modport slave (
    input  cpu_req, cpu_addr, mem_rdata, mem_ack,
    output cpu_ready, cpu_rdata, mem_req, mem_addr
  );
endinterface

// File: rtl/tag_data_store.sv
// Tag and data arrays for the 4-line cache: synchronous write, combinational
// read at the same index. Contents are deliberately not reset.
module tag_data_store
  import cache_pkg::*;
#(
  parameter int TAG_W  = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [LINE_W-1:0] idx,
  input  logic [TAG_W-1:0]  wtag,
  input  logic [DATA_W-1:0] wdata,
  output logic [TAG_W-1:0]  rtag,
  output logic [DATA_W-1:0] rdata
);

  logic [TAG_W-1:0]  tag_mem  [NUM_LINES];
  logic [DATA_W-1:0] data_mem [NUM_LINES];

  // Validity lives in the external valid array, so stale contents are harmless.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[idx]  <= wtag;
      data_mem[idx] <= wdata;
    end
  end

  assign rtag  = tag_mem[idx];
  assign rdata = data_mem[idx];

endmodule

// File: rtl/cache_ctrl.sv
// Lookup/refill controller for a 4-line direct-mapped read-only cache.
// Owns the FSM, the address latch, the read-data register and the counters.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  cache_ctrl_if.slave       bus,
  output logic [LINE_W-1:0] line,
  input  logic              valid_in,
  output logic              valid_wr,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output cache_state_e      state_dbg
);

  localparam int TAG_W = tag_width(ADDR_W);

  cache_state_e      state;
  cache_state_e      state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rdata_q;
  logic [CNT_W-1:0]  hit_cnt_q;
  logic [CNT_W-1:0]  miss_cnt_q;

  logic [TAG_W-1:0]  addr_tag;
  logic [TAG_W-1:0]  store_tag;
  logic [DATA_W-1:0] store_data;
  logic              hit;
  logic              fill_ack;
  logic              cpu_ready_c;
  logic              mem_req_c;

  assign addr_tag = addr_q[ADDR_W-1:LINE_W];
  assign line     = addr_q[LINE_W-1:0];
  assign hit      = valid_in && (store_tag == addr_tag);

  tag_data_store #(
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_store (
    .clk   (clk),
    .we    (fill_ack),
    .idx   (line),
    .wtag  (addr_tag),
    .wdata (bus.mem_rdata),
    .rtag  (store_tag),
    .rdata (store_data)
  );

  // State register; reset drops straight to IDLE so mem_req falls asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.cpu_req) state_nx = LOOKUP;
      LOOKUP:  state_nx = hit ? RESPOND : FILL;
      FILL:    if (bus.mem_ack) state_nx = RESPOND;
      RESPOND: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cpu_ready_c = 1'b0;
    mem_req_c   = 1'b0;
    fill_ack    = 1'b0;
    unique case (state)
      FILL: begin
        mem_req_c = 1'b1;
        fill_ack  = bus.mem_ack;
      end
      RESPOND: cpu_ready_c = 1'b1;
      default: ;
    endcase
  end

  // rdata_q only changes on the way into RESPOND, so it holds between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      rdata_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (state == IDLE && bus.cpu_req) begin
        addr_q <= bus.cpu_addr;
      end
      if (state == LOOKUP) begin
        if (hit) begin
          rdata_q <= store_data;
          if (hit_cnt_q != {CNT_W{1'b1}}) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
        end else begin
          if (miss_cnt_q != {CNT_W{1'b1}}) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
        end
      end
      if (fill_ack) begin
        rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.cpu_ready = cpu_ready_c;
  assign bus.cpu_rdata = rdata_q;
  assign bus.mem_req   = mem_req_c;
  assign bus.mem_addr  = addr_q;
  assign valid_wr      = fill_ack;
  assign hit_cnt       = hit_cnt_q;
  assign miss_cnt      = miss_cnt_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_cache_ctrl.sv
// Randomized scoreboard bench for cache_ctrl with an array-based cache model,
// a memory responder and a valid-bit array model.
module tb_cache_ctrl;
  import cache_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cache_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  logic [1:0]       line;
  logic             valid_in;
  logic             valid_wr;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;
  cache_state_e     state_dbg;

  cache_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .line      (line),
    .valid_in  (valid_in),
    .valid_wr  (valid_wr),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt),
    .state_dbg (state_dbg)
  );

  // External valid-bit array, cleared by the same reset.
  logic [3:0] valid_arr;
  always @(posedge clk or posedge reset) begin
    if (reset) valid_arr <= '0;
    else if (valid_wr) valid_arr[line] <= 1'b1;
  end
  assign valid_in = valid_arr[line];

  // ---------------- check bookkeeping ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [7:0] mem_image [256];
  logic [5:0] m_tag   [4];
  bit         m_valid [4];
  int         m_hc;
  int         m_mc;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
    end
    m_hc = 0;
    m_mc = 0;
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    bit         hit;
    logic [7:0] hc;
    logic [7:0] mc;
    int         issue_cyc;
  } exp_t;

  exp_t exp_q[$];

  // ---------------- shared stimulus state ----------------
  logic [7:0] cur_addr     = '0;
  bit         hold_ack     = 1'b0;
  bit         inject_ack   = 1'b0;
  int         forced_wait  = -1;
  int         ack_cyc      = 0;
  bit         mem_req_seen = 1'b0;

  // ---------------- driver ----------------
  task automatic do_read(input logic [7:0] addr);
    exp_t       e;
    int         idx;
    logic [5:0] tag;
    bit         ok;
    idx = int'(addr[1:0]);
    tag = addr[7:2];
    e.addr = addr;
    e.hit  = m_valid[idx] && (m_tag[idx] == tag);
    if (e.hit) begin
      if (m_hc < 255) m_hc++;
    end else begin
      if (m_mc < 255) m_mc++;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
    end
    e.data = mem_image[addr];
    e.hc   = 8'(m_hc);
    e.mc   = 8'(m_mc);
    @(posedge clk); #1;
    cur_addr     = addr;
    mem_req_seen = 1'b0;
    e.issue_cyc  = cyc;
    exp_q.push_back(e);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = addr;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.cpu_ready) begin
        ok = 1'b1;
        break;
      end
    end
    bus.cpu_req = 1'b0;
    if (!ok) begin
      chk("ready_timeout", 32'(ok), 32'd1);
      exp_q.delete();
    end
  endtask

  // ---------------- memory responder ----------------
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (inject_ack) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'hEE;
        @(negedge clk);
        chk("late_ack_valid_wr", 32'(valid_wr), 32'd0);
        chk("late_ack_ready", 32'(bus.cpu_ready), 32'd0);
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        inject_ack  = 1'b0;
      end else if (bus.mem_req && !hold_ack) begin
        int w;
        w = (forced_wait >= 0) ? forced_wait : int'($urandom_range(0, 3));
        repeat (w) begin
          @(posedge clk); #1;
        end
        if (bus.mem_req) begin
          chk("mem_addr", 32'(bus.mem_addr), 32'(cur_addr));
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem_image[cur_addr];
          ack_cyc       = cyc;
          @(negedge clk);
          chk("fill_valid_wr", 32'(valid_wr), 32'd1);
          chk("fill_line", 32'(line), 32'(cur_addr[1:0]));
          @(posedge clk); #1;
          bus.mem_ack = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (bus.mem_req) mem_req_seen = 1'b1;
      if (!reset && bus.cpu_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ready", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(e.data));
          chk("hit_cnt", 32'(hit_cnt), 32'(e.hc));
          chk("miss_cnt", 32'(miss_cnt), 32'(e.mc));
          chk("mem_req_used", 32'(mem_req_seen), 32'(!e.hit));
          if (e.hit) chk("hit_latency", 32'(cyc - e.issue_cyc), 32'd2);
          else       chk("miss_latency", 32'(cyc - ack_cyc), 32'd1);
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    bit seen;
    bus.cpu_req  = 1'b0;
    bus.cpu_addr = '0;
    for (int i = 0; i < 256; i++) mem_image[i] = 8'($urandom_range(0, 255));
    mem_image[8'h15] = 8'hA5;
    mem_image[8'h25] = 8'h5C;
    mem_image[8'h22] = 8'h77;
    model_reset();

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
    chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
    chk("rst_valid_wr", 32'(valid_wr), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_line", 32'(line), 32'd0);
    chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    reset = 1'b0;

    // Cold miss with a 3-cycle refill wait, then a hit, then a conflict pair.
    forced_wait = 3;
    do_read(8'h15);
    forced_wait = -1;
    do_read(8'h15);
    do_read(8'h25);
    do_read(8'h15);

    // Reset two cycles into FILL.
    hold_ack = 1'b1;
    @(posedge clk); #1;
    cur_addr     = 8'h3A;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 8'h3A;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.mem_req) begin
        seen = 1'b1;
        break;
      end
    end
    bus.cpu_req = 1'b0;
    chk("fill_reached", 32'(seen), 32'd1);
    chk("fill_mem_addr", 32'(bus.mem_addr), 32'h3A);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midrst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("midrst_state", 32'(state_dbg), 32'(IDLE));
    chk("midrst_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("midrst_miss_cnt", 32'(miss_cnt), 32'd0);
    exp_q.delete();
    model_reset();
    @(posedge clk); #1;
    reset    = 1'b0;
    hold_ack = 1'b0;
    inject_ack = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!inject_ack) begin
        seen = 1'b1;
        break;
      end
    end
    chk("inject_done", 32'(seen), 32'd1);
    do_read(8'h15);

    // Zero-wait refill on line 2.
    forced_wait = 0;
    do_read(8'h22);
    forced_wait = -1;

    // Random reads over a small address pool to force hits and conflicts.
    repeat (60) begin
      logic [7:0] a;
      a = {6'($urandom_range(0, 2)), 2'($urandom_range(0, 3))};
      do_read(a);
    end

    // Hit-counter saturation.
    do_read(8'h15);
    repeat (300) do_read(8'h15);
    chk("hit_saturated", 32'(hit_cnt), 32'hFF);
    chk("miss_after_sat", 32'(miss_cnt), 32'(8'(m_mc)));

    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time bound.
  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
